// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, keypad FSM states, operand width
// and the keypad row/column decode helpers.
package calc_pkg;

  localparam int NUM_W = 10;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_CLR = 4'd14;
  localparam logic [3:0] KEY_EQ  = 4'd15;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, REPORT, RELEASE} kp_state_e;

  // Index of the lowest active-low row in a row pattern
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  // Physical keypad layout to key code
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = KEY_ADD;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = KEY_SUB;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = KEY_MUL;
      4'b11_00: code = KEY_CLR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_EQ;
      default:  code = KEY_DIV;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchronizer, debounce FSM,
// one-cycle key_valid pulse with held key_code.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  kp_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       row_meta_q, row_meta_d;
  logic [3:0]       row_sync_q, row_sync_d;
  logic [3:0]       row_pat_q, row_pat_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             period_end;

  assign period_end = (div_q == DIV_LAST);
  assign col_out    = ~(4'b0001 << col_q);
  assign key_valid  = key_valid_q;
  assign key_code   = key_code_q;

  // Scan divider, synchronizer and debounce FSM next-state
  always_comb begin
    state_d     = state_q;
    div_d       = period_end ? '0 : div_q + DIV_W'(1);
    cnt_d       = cnt_q;
    col_d       = col_q;
    row_meta_d  = row_in;
    row_sync_d  = row_meta_q;
    row_pat_d   = row_pat_q;
    row_idx_d   = row_idx_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    case (state_q)
      SCAN: if (period_end) begin
        if (row_sync_q == 4'hF) begin
          col_d = col_q + 2'd1;
        end else begin
          row_pat_d = row_sync_q;
          row_idx_d = lowest_low_row(row_sync_q);
          cnt_d     = '0;
          state_d   = DEBOUNCE;
        end
      end
      DEBOUNCE: if (period_end) begin
        if (row_sync_q == row_pat_q) begin
          if (cnt_q == CNT_LAST) begin
            // key_valid is registered so it is high during the REPORT cycle
            state_d     = REPORT;
            cnt_d       = '0;
            key_valid_d = 1'b1;
            key_code_d  = key_lookup(row_idx_q, col_q);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
        end
      end
      REPORT: begin
        state_d = RELEASE;
        cnt_d   = '0;
      end
      RELEASE: if (period_end) begin
        if (row_sync_q == 4'hF) begin
          if (cnt_q == CNT_LAST) begin
            state_d = SCAN;
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // FSM and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= SCAN;
      div_q       <= '0;
      cnt_q       <= '0;
      col_q       <= 2'd0;
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      row_pat_q   <= 4'hF;
      row_idx_q   <= 2'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      row_meta_q  <= row_meta_d;
      row_sync_q  <= row_sync_d;
      row_pat_q   <= row_pat_d;
      row_idx_q   <= row_idx_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

endmodule

// File: rtl/keypad_num_entry.sv
// Keypad number entry: scanner plus operand assembly (0-999), operator,
// equals and clear events.
// Optional KEYPAD_BCD_OUT_EN adds a packed 3-digit BCD copy of the operand.
module keypad_num_entry
  import calc_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int MAX_DIGITS     = 3
) (
  input  logic             clk,
  input  logic             rst,
  output logic [3:0]       col_out,
  input  logic [3:0]       row_in,
  output logic [NUM_W-1:0] num,
  output logic [1:0]       digit_cnt,
  output logic             key_valid,
  output logic [3:0]       key_code,
  output logic             op_valid,
  output logic [3:0]       op_code,
  output logic             clr_valid
`ifdef KEYPAD_BCD_OUT_EN
  ,
  output logic [11:0]      bcd
`endif
);

  localparam logic [1:0] MAXD = 2'(MAX_DIGITS);

  logic [NUM_W-1:0] num_q, num_d, num_x10;
  logic [1:0]       digit_cnt_q, digit_cnt_d;
  logic             entry_done_q, entry_done_d;
  logic             op_valid_q, op_valid_d;
  logic [3:0]       op_code_q, op_code_d;
  logic             clr_valid_q, clr_valid_d;
`ifdef KEYPAD_BCD_OUT_EN
  logic [11:0]      bcd_q, bcd_d;
  assign bcd = bcd_q;
`endif

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  // num*10 + d without a multiplier; 99*10+9 fits the operand width
  assign num_x10 = (num_q << 3) + (num_q << 1) + NUM_W'(key_code);

  assign num       = num_q;
  assign digit_cnt = digit_cnt_q;
  assign op_valid  = op_valid_q;
  assign op_code   = op_code_q;
  assign clr_valid = clr_valid_q;

  // Entry rules applied on each accepted key
  always_comb begin
    num_d        = num_q;
    digit_cnt_d  = digit_cnt_q;
    entry_done_d = entry_done_q;
    op_valid_d   = 1'b0;
    op_code_d    = op_code_q;
    clr_valid_d  = 1'b0;
`ifdef KEYPAD_BCD_OUT_EN
    bcd_d        = bcd_q;
`endif
    if (key_valid) begin
      if (key_code < 4'd10) begin
        if (entry_done_q) begin
          // first digit after an operator starts a fresh operand
          num_d        = NUM_W'(key_code);
          digit_cnt_d  = 2'd1;
          entry_done_d = 1'b0;
`ifdef KEYPAD_BCD_OUT_EN
          bcd_d        = {8'h00, key_code};
`endif
        end else if (digit_cnt_q < MAXD) begin
          num_d       = num_x10;
          digit_cnt_d = digit_cnt_q + 2'd1;
`ifdef KEYPAD_BCD_OUT_EN
          bcd_d       = {bcd_q[7:0], key_code};
`endif
        end
      end else if (key_code == KEY_CLR) begin
        num_d        = '0;
        digit_cnt_d  = 2'd0;
        entry_done_d = 1'b0;
        clr_valid_d  = 1'b1;
`ifdef KEYPAD_BCD_OUT_EN
        bcd_d        = 12'h000;
`endif
      end else begin
        op_valid_d   = 1'b1;
        op_code_d    = key_code;
        entry_done_d = 1'b1;
      end
    end
  end

  // Entry state and event registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      num_q        <= '0;
      digit_cnt_q  <= 2'd0;
      entry_done_q <= 1'b0;
      op_valid_q   <= 1'b0;
      op_code_q    <= 4'd0;
      clr_valid_q  <= 1'b0;
`ifdef KEYPAD_BCD_OUT_EN
      bcd_q        <= 12'h000;
`endif
    end else begin
      num_q        <= num_d;
      digit_cnt_q  <= digit_cnt_d;
      entry_done_q <= entry_done_d;
      op_valid_q   <= op_valid_d;
      op_code_q    <= op_code_d;
      clr_valid_q  <= clr_valid_d;
`ifdef KEYPAD_BCD_OUT_EN
      bcd_q        <= bcd_d;
`endif
    end
  end

endmodule
